// File: rtl/tensor_tile_sched_pkg.sv
// Shared types for the tensor tile scheduler: FSM state encoding, read-select
// encoding and the burst-length helper.
package tensor_tile_sched_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LD_C    = 4'd1,
    ST_LD_A    = 4'd2,
    ST_LD_B    = 4'd3,
    ST_PE_GO   = 4'd4,
    ST_PE_WAIT = 4'd5,
    ST_ST_D    = 4'd6,
    ST_ST_WAIT = 4'd7,
    ST_FIN     = 4'd8
  } state_e;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;

  // AXI-style burst length field: beats per tile minus one.
  function automatic logic [7:0] burst_len(input int tile_bytes, input int data_w);
    return 8'(tile_bytes / (data_w / 8) - 1);
  endfunction

endpackage

// File: rtl/tensor_tile_addr.sv
// Combinational tile address generator: base + index * TILE_BYTES, wrapping
// modulo 2^ADDR_W.
module tensor_tile_addr #(
  parameter int ADDR_W     = 32,
  parameter int IDX_W      = 16,
  parameter int TILE_BYTES = 1024
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [IDX_W-1:0]  index,
  output logic [ADDR_W-1:0] addr
);

  localparam int SHIFT = $clog2(TILE_BYTES);

  logic [ADDR_W-1:0] offset;

  always_comb begin
    offset = ADDR_W'(index) << SHIFT;
    addr   = base + offset;
  end

endmodule

// File: rtl/tensor_tile_sched.sv
// Tile scheduler for a systolic GEMM: walks (mi, ni) row-major with ki innermost,
// issuing C/A/B read bursts, PE steps and D write bursts.
module tensor_tile_sched
  import tensor_tile_sched_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 8,
  parameter int TILE_BYTES = 1024,
  parameter int DATA_W     = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_base_a,
  input  logic [ADDR_W-1:0] cfg_base_b,
  input  logic [ADDR_W-1:0] cfg_base_c,
  input  logic [ADDR_W-1:0] cfg_base_d,
  input  logic [CNT_W-1:0]  cfg_m,
  input  logic [CNT_W-1:0]  cfg_n,
  input  logic [CNT_W-1:0]  cfg_k,
  output logic              rd_cmd_valid,
  input  logic              rd_cmd_ready,
  output logic [ADDR_W-1:0] rd_cmd_addr,
  output logic [7:0]        rd_cmd_len,
  output logic [1:0]        rd_cmd_sel,
  output logic              wr_cmd_valid,
  input  logic              wr_cmd_ready,
  output logic [ADDR_W-1:0] wr_cmd_addr,
  output logic [7:0]        wr_cmd_len,
  input  logic              wr_done,
  output logic              pe_start,
  input  logic              pe_done,
  output logic              busy,
  output logic              cfg_done,
  output logic [3:0]        dbg_state
);

  // Handshake: a command is transferred on any cycle where valid && ready are
  // both high at the rising clock edge; once valid rises, valid/addr/len/sel
  // hold unchanged until that transfer, because they decode only from state
  // and counters that move solely on acceptance.

  localparam int IDX_W = 2 * CNT_W;
  localparam logic [7:0] LEN = burst_len(TILE_BYTES, DATA_W);

  state_e state_q, state_d;
  logic [CNT_W-1:0]  mi_q, mi_d, ni_q, ni_d, ki_q, ki_d;
  logic [CNT_W-1:0]  m_q, m_d, n_q, n_d, k_q, k_d;
  logic [ADDR_W-1:0] base_a_q, base_a_d, base_b_q, base_b_d;
  logic [ADDR_W-1:0] base_c_q, base_c_d, base_d_q, base_d_d;

  logic [IDX_W-1:0]  idx_a, idx_b, idx_cd;
  logic [ADDR_W-1:0] mux_base, tile_addr;
  logic [IDX_W-1:0]  mux_idx;
  logic [1:0]        mux_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mi_q     <= '0;
      ni_q     <= '0;
      ki_q     <= '0;
      m_q      <= '0;
      n_q      <= '0;
      k_q      <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      base_c_q <= '0;
      base_d_q <= '0;
    end else begin
      state_q  <= state_d;
      mi_q     <= mi_d;
      ni_q     <= ni_d;
      ki_q     <= ki_d;
      m_q      <= m_d;
      n_q      <= n_d;
      k_q      <= k_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      base_c_q <= base_c_d;
      base_d_q <= base_d_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mi_d     = mi_q;
    ni_d     = ni_q;
    ki_d     = ki_q;
    m_d      = m_q;
    n_d      = n_q;
    k_d      = k_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    base_c_d = base_c_q;
    base_d_d = base_d_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          m_d      = cfg_m;
          n_d      = cfg_n;
          k_d      = cfg_k;
          base_a_d = cfg_base_a;
          base_b_d = cfg_base_b;
          base_c_d = cfg_base_c;
          base_d_d = cfg_base_d;
          mi_d     = '0;
          ni_d     = '0;
          ki_d     = '0;
          if (cfg_m == '0 || cfg_n == '0 || cfg_k == '0) state_d = ST_FIN;
          else                                           state_d = ST_LD_C;
        end
      end
      ST_LD_C: if (rd_cmd_ready) state_d = ST_LD_A;
      ST_LD_A: if (rd_cmd_ready) state_d = ST_LD_B;
      ST_LD_B: if (rd_cmd_ready) state_d = ST_PE_GO;
      ST_PE_GO: state_d = ST_PE_WAIT;
      ST_PE_WAIT: begin
        if (pe_done) begin
          if (ki_q != k_q - CNT_W'(1)) begin
            ki_d    = ki_q + CNT_W'(1);
            state_d = ST_LD_A;
          end else begin
            ki_d    = '0;
            state_d = ST_ST_D;
          end
        end
      end
      ST_ST_D: if (wr_cmd_ready) state_d = ST_ST_WAIT;
      ST_ST_WAIT: begin
        if (wr_done) begin
          if (ni_q != n_q - CNT_W'(1)) begin
            ni_d    = ni_q + CNT_W'(1);
            state_d = ST_LD_C;
          end else begin
            ni_d = '0;
            // Last column of the last row ends the job.
            if (mi_q != m_q - CNT_W'(1)) begin
              mi_d    = mi_q + CNT_W'(1);
              state_d = ST_LD_C;
            end else begin
              mi_d    = '0;
              state_d = ST_FIN;
            end
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idx_a  = IDX_W'(mi_q) * IDX_W'(k_q) + IDX_W'(ki_q);
    idx_b  = IDX_W'(ki_q) * IDX_W'(n_q) + IDX_W'(ni_q);
    idx_cd = IDX_W'(mi_q) * IDX_W'(n_q) + IDX_W'(ni_q);
  end

  // Idle states select base 0 / index 0 so both address outputs read zero.
  always_comb begin
    mux_base = '0;
    mux_idx  = '0;
    mux_sel  = SEL_A;
    case (state_q)
      ST_LD_C: begin mux_base = base_c_q; mux_idx = idx_cd; mux_sel = SEL_C; end
      ST_LD_A: begin mux_base = base_a_q; mux_idx = idx_a;  mux_sel = SEL_A; end
      ST_LD_B: begin mux_base = base_b_q; mux_idx = idx_b;  mux_sel = SEL_B; end
      ST_ST_D: begin mux_base = base_d_q; mux_idx = idx_cd; end
      default: ;
    endcase
  end

  tensor_tile_addr #(
    .ADDR_W    (ADDR_W),
    .IDX_W     (IDX_W),
    .TILE_BYTES(TILE_BYTES)
  ) u_addr (
    .base (mux_base),
    .index(mux_idx),
    .addr (tile_addr)
  );

  assign rd_cmd_valid = (state_q == ST_LD_C) || (state_q == ST_LD_A) || (state_q == ST_LD_B);
  assign rd_cmd_addr  = tile_addr;
  assign rd_cmd_len   = LEN;
  assign rd_cmd_sel   = mux_sel;
  assign wr_cmd_valid = (state_q == ST_ST_D);
  assign wr_cmd_addr  = tile_addr;
  assign wr_cmd_len   = LEN;
  assign pe_start     = (state_q == ST_PE_GO);
  assign busy         = (state_q != ST_IDLE);
  assign cfg_done     = (state_q == ST_FIN);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_tensor_tile_sched.sv
// Directed bench for tensor_tile_sched: command logs recorded by a monitor and
// checked against hand-computed tile addresses and orderings.
module tb_tensor_tile_sched;
  import tensor_tile_sched_pkg::*;

  logic        clk, rst_n, cfg_start;
  logic [31:0] cfg_base_a, cfg_base_b, cfg_base_c, cfg_base_d;
  logic [7:0]  cfg_m, cfg_n, cfg_k;
  logic        rd_cmd_valid, rd_cmd_ready, wr_cmd_valid, wr_cmd_ready;
  logic [31:0] rd_cmd_addr, wr_cmd_addr;
  logic [7:0]  rd_cmd_len, wr_cmd_len;
  logic [1:0]  rd_cmd_sel;
  logic        wr_done, pe_start, pe_done, busy, cfg_done;
  logic [3:0]  dbg_state;

  logic [33:0] rd_q[$];
  logic [31:0] wr_q[$];
  logic [7:0]  wr_len_q[$];
  logic [33:0] exp_q[$];
  int pe_cnt = 0, done_cnt = 0;
  int n_pass = 0, n_total = 0;
  logic pe_hold = 1'b0;
  int rd_s, wr_s, pe_s, dn_s;

  tensor_tile_sched dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
    .cfg_base_a(cfg_base_a), .cfg_base_b(cfg_base_b),
    .cfg_base_c(cfg_base_c), .cfg_base_d(cfg_base_d),
    .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
    .rd_cmd_addr(rd_cmd_addr), .rd_cmd_len(rd_cmd_len), .rd_cmd_sel(rd_cmd_sel),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
    .wr_cmd_addr(wr_cmd_addr), .wr_cmd_len(wr_cmd_len), .wr_done(wr_done),
    .pe_start(pe_start), .pe_done(pe_done), .busy(busy), .cfg_done(cfg_done),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: records accepted commands and pulses at the falling edge.
  always @(negedge clk) begin
    if (rd_cmd_valid && rd_cmd_ready) rd_q.push_back({rd_cmd_sel, rd_cmd_addr});
    if (wr_cmd_valid && wr_cmd_ready) begin
      wr_q.push_back(wr_cmd_addr);
      wr_len_q.push_back(wr_cmd_len);
    end
    if (pe_start) pe_cnt++;
    if (cfg_done) done_cnt++;
  end

  // Responders: completion pulses a few cycles after each request.
  initial pe_done = 1'b0;
  always begin
    @(negedge clk);
    if (pe_start && !pe_hold) begin
      repeat (2) @(posedge clk);
      #1 pe_done = 1'b1;
      @(posedge clk);
      #1 pe_done = 1'b0;
    end
  end

  initial wr_done = 1'b0;
  always begin
    @(negedge clk);
    if (wr_cmd_valid && wr_cmd_ready) begin
      repeat (2) @(posedge clk);
      #1 wr_done = 1'b1;
      @(posedge clk);
      #1 wr_done = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Driver: one-cycle start pulse; returns just after the capturing edge.
  task automatic start_job(input logic [31:0] ba, bb, bc, bd,
                           input logic [7:0] m, n, k);
    @(posedge clk); #1;
    cfg_base_a = ba; cfg_base_b = bb; cfg_base_c = bc; cfg_base_d = bd;
    cfg_m = m; cfg_n = n; cfg_k = k;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic snap();
    rd_s = rd_q.size(); wr_s = wr_q.size(); pe_s = pe_cnt; dn_s = done_cnt;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (done_cnt != dn_s) break;
    end
    check(tag, 64'(done_cnt - dn_s), 64'd1);
  endtask

  task automatic wait_state(input string tag, input logic [3:0] st, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (dbg_state == st) break;
    end
    check(tag, 64'(dbg_state), 64'(st));
  endtask

  initial begin
    rst_n = 1'b0; cfg_start = 1'b0;
    cfg_base_a = '0; cfg_base_b = '0; cfg_base_c = '0; cfg_base_d = '0;
    cfg_m = '0; cfg_n = '0; cfg_k = '0;
    rd_cmd_ready = 1'b1; wr_cmd_ready = 1'b1;

    // Reset state
    #2;
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("rst_outs", {58'd0, rd_cmd_valid, wr_cmd_valid, pe_start, busy, cfg_done, 1'b0}, 64'd0);
    check("rst_addrs", {rd_cmd_addr, wr_cmd_addr}, 64'd0);
    check("burst_len", {48'd0, rd_cmd_len, wr_cmd_len}, {48'd0, 8'd31, 8'd31});
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single tile job
    snap();
    start_job(32'h1000, 32'h2000, 32'h3000, 32'h4000, 8'd1, 8'd1, 8'd1);
    wait_done("t1_done", 200);
    check("t1_rd_cnt", 64'(rd_q.size() - rd_s), 64'd3);
    check("t1_rd0", 64'(rd_q[rd_s]),     {30'd0, 2'd2, 32'h3000});
    check("t1_rd1", 64'(rd_q[rd_s + 1]), {30'd0, 2'd0, 32'h1000});
    check("t1_rd2", 64'(rd_q[rd_s + 2]), {30'd0, 2'd1, 32'h2000});
    check("t1_pe", 64'(pe_cnt - pe_s), 64'd1);
    check("t1_wr_cnt", 64'(wr_q.size() - wr_s), 64'd1);
    check("t1_wr0", 64'(wr_q[wr_s]), 64'h4000);
    check("t1_wr_len", 64'(wr_len_q[wr_s]), 64'd31);
    repeat (3) @(posedge clk); #1;
    check("t1_idle", 64'(busy), 64'd0);

    // Zero count: FIN on the cycle after start, no commands
    snap();
    start_job(32'h1000, 32'h2000, 32'h3000, 32'h4000, 8'd2, 8'd2, 8'd0);
    check("z_done_hi", {62'd0, cfg_done, busy}, 64'd3);
    check("z_no_rd", 64'(rd_cmd_valid), 64'd0);
    @(posedge clk); #1;
    check("z_done_lo", {62'd0, cfg_done, busy}, 64'd0);
    check("z_cmds", 64'((rd_q.size() - rd_s) + (wr_q.size() - wr_s) + (pe_cnt - pe_s)), 64'd0);

    // 2x2x3 job with a stray start in the middle
    snap();
    start_job(32'h10000, 32'h20000, 32'h30000, 32'h40000, 8'd2, 8'd2, 8'd3);
    repeat (20) @(posedge clk);
    #1 cfg_start = 1'b1; cfg_k = 8'd0; cfg_base_a = 32'hDEAD0000;
    @(posedge clk);
    #1 cfg_start = 1'b0;
    wait_done("t2_done", 1500);
    exp_q.delete();
    for (int mi = 0; mi < 2; mi++)
      for (int ni = 0; ni < 2; ni++) begin
        exp_q.push_back({2'd2, 32'h30000 + 32'((mi * 2 + ni) * 1024)});
        for (int ki = 0; ki < 3; ki++) begin
          exp_q.push_back({2'd0, 32'h10000 + 32'((mi * 3 + ki) * 1024)});
          exp_q.push_back({2'd1, 32'h20000 + 32'((ki * 2 + ni) * 1024)});
        end
      end
    check("t2_rd_cnt", 64'(rd_q.size() - rd_s), 64'd28);
    for (int i = 0; i < 28; i++)
      check($sformatf("t2_rd%0d", i), 64'(rd_q[rd_s + i]), 64'(exp_q[i]));
    check("t2_a_idx5", 64'(rd_q[rd_s + 26]), {30'd0, 2'd0, 32'h11400});
    check("t2_b_idx5", 64'(rd_q[rd_s + 27]), {30'd0, 2'd1, 32'h21400});
    check("t2_pe", 64'(pe_cnt - pe_s), 64'd12);
    check("t2_wr_cnt", 64'(wr_q.size() - wr_s), 64'd4);
    check("t2_wr0", 64'(wr_q[wr_s]),     64'h40000);
    check("t2_wr1", 64'(wr_q[wr_s + 1]), 64'h40400);
    check("t2_wr2", 64'(wr_q[wr_s + 2]), 64'h40800);
    check("t2_wr3", 64'(wr_q[wr_s + 3]), 64'h40C00);
    repeat (5) @(posedge clk); #2;
    check("t2_one_done", 64'(done_cnt - dn_s), 64'd1);

    // Backpressure in LD_A
    snap();
    rd_cmd_ready = 1'b0;
    start_job(32'h1000, 32'h2000, 32'h3000, 32'h4000, 8'd1, 8'd1, 8'd1);
    wait_state("bp_in_ldc", ST_LD_C, 20);
    rd_cmd_ready = 1'b1;
    @(posedge clk); #1;
    rd_cmd_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_state%0d", i), 64'(dbg_state), 64'(ST_LD_A));
      check($sformatf("bp_cmd%0d", i), {29'd0, rd_cmd_valid, rd_cmd_sel, rd_cmd_addr},
            {29'd0, 1'b1, 2'd0, 32'h1000});
      @(posedge clk); #1;
    end
    rd_cmd_ready = 1'b1;
    wait_done("bp_done", 200);
    check("bp_rd_cnt", 64'(rd_q.size() - rd_s), 64'd3);

    // Address wrap past 2^32
    snap();
    start_job(32'hFFFFFC00, 32'h2000, 32'h3000, 32'h4000, 8'd1, 8'd1, 8'd2);
    wait_done("wrap_done", 300);
    check("wrap_a0", 64'(rd_q[rd_s + 1]), {30'd0, 2'd0, 32'hFFFFFC00});
    check("wrap_a1", 64'(rd_q[rd_s + 3]), {30'd0, 2'd0, 32'h00000000});
    check("wrap_b1", 64'(rd_q[rd_s + 4]), {30'd0, 2'd1, 32'h00002400});

    // Asynchronous reset while waiting on the PE
    pe_hold = 1'b1;
    snap();
    start_job(32'h1000, 32'h2000, 32'h3000, 32'h4000, 8'd1, 8'd1, 8'd1);
    wait_state("ar_pe_wait", ST_PE_WAIT, 50);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("ar_state", 64'(dbg_state), 64'(ST_IDLE));
    check("ar_outs", {58'd0, rd_cmd_valid, wr_cmd_valid, pe_start, busy, cfg_done, 1'b0}, 64'd0);
    check("ar_addrs", {rd_cmd_addr, wr_cmd_addr}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pe_hold = 1'b0;
    snap();
    repeat (10) @(posedge clk); #2;
    check("ar_quiet", 64'((rd_q.size() - rd_s) + (done_cnt - dn_s) + (pe_cnt - pe_s)), 64'd0);
    start_job(32'h1000, 32'h2000, 32'h3000, 32'h4000, 8'd1, 8'd1, 8'd1);
    wait_done("ar_rerun_done", 200);
    check("ar_rd0", 64'(rd_q[rd_s]),     {30'd0, 2'd2, 32'h3000});
    check("ar_rd1", 64'(rd_q[rd_s + 1]), {30'd0, 2'd0, 32'h1000});
    check("ar_rd2", 64'(rd_q[rd_s + 2]), {30'd0, 2'd1, 32'h2000});
    check("ar_wr0", 64'(wr_q[wr_s]), 64'h4000);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
